// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and load clamping for the modulo counters
package counter_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  function automatic logic [31:0] clamp_load(input logic [31:0] v, input logic [31:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction
endpackage

// File: rtl/mod_next_state.sv
// mod_next_state: next count, wrap flag and terminal count for a modulo up/down counter
module mod_next_state import counter_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int MODULUS = 32
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o,
  output logic             tc_o
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic at_max, at_zero, is_up;
  always_comb begin
    is_up = (up_i == CNT_UP);
    at_max = (q_i == MAX);
    at_zero = (q_i == '0);
    wrap_o = en_i && (is_up ? at_max : at_zero);
    tc_o = wrap_o;
    q_o = !en_i ? q_i
        : is_up ? (at_max ? '0 : q_i + WIDTH'(1))
        : (at_zero ? MAX : q_i - WIDTH'(1));
  end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous up/down modulo counter with load, preset and cascade outputs
module mod_updown_counter import counter_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int MODULUS = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
    $error("mod_updown_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
  end
  logic [WIDTH-1:0] q_q, q_d, cnt_q;
  logic wrap_q, wrap_d, cnt_wrap, cnt_tc, ovr;
  mod_next_state #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .q_i(q_q), .en_i(en), .up_i(up), .q_o(cnt_q), .wrap_o(cnt_wrap), .tc_o(cnt_tc)
  );
  always_comb begin
    ovr = clear | preset | load;
    q_d = clear ? '0 : preset ? MAX : load ? WIDTH'(clamp_load(32'(load_val), 32'(MAX))) : cnt_q;
    wrap_d = !ovr && cnt_wrap;
  end
  always_ff @(posedge clk) begin
    q_q <= q_d;
    wrap_q <= wrap_d;
  end
  assign q = q_q;
  assign wrap = wrap_q;
  assign tc = cnt_tc && !ovr;
`ifndef SYNTHESIS
  logic rst_seen_q, tc_prev_q;
  always_ff @(posedge clk) begin
    rst_seen_q <= rst_seen_q | clear;
    tc_prev_q <= tc;
  end
  a_in_range: assert property (@(posedge clk) rst_seen_q |-> q_q <= MAX);
  a_wrap_after_tc: assert property (@(posedge clk) rst_seen_q && wrap_q |-> tc_prev_q);
`endif
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed scoreboard bench for default, decade and cascaded counters
module tb_mod_updown_counter;
  typedef struct {int sel; int q; bit wrap; bit tc;} exp_t;
  logic clk = 1'b0;
  logic clear = 1'b1, preset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [4:0] lv = '0;
  logic [4:0] a_q;
  logic a_tc, a_wrap;
  logic [3:0] b_q, lo_q, hi_q;
  logic b_tc, b_wrap, lo_tc, lo_wrap, hi_tc, hi_wrap;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  mod_updown_counter u_a (
    .clk(clk), .clear(clear), .preset(preset), .en(en), .up(up), .load(load),
    .load_val(lv), .q(a_q), .tc(a_tc), .wrap(a_wrap)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .clear(clear), .preset(preset), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(b_q), .tc(b_tc), .wrap(b_wrap)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clear(clear), .preset(1'b0), .en(en), .up(up), .load(1'b0),
    .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .clear(clear), .preset(1'b0), .en(lo_tc), .up(up), .load(1'b0),
    .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );
  function automatic int cur_q(int sel);
    return sel == 0 ? int'(a_q) : sel == 1 ? int'(b_q) : int'(hi_q) * 10 + int'(lo_q);
  endfunction
  function automatic bit cur_tc(int sel);
    return sel == 0 ? a_tc : sel == 1 ? b_tc : hi_tc;
  endfunction
  function automatic bit cur_wrap(int sel);
    return sel == 0 ? a_wrap : sel == 1 ? b_wrap : hi_wrap;
  endfunction
  // tc is checked just before the edge that consumes the vector, q/wrap just after it
  initial forever begin
    @(negedge clk);
    #4;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (cur_tc(e.sel) !== e.tc) begin
        miscompares++;
        $display("FAIL tc sel=%0d vec=%0d: got %b want %b", e.sel, vectors, cur_tc(e.sel), e.tc);
      end
      @(posedge clk);
      #1;
      if (cur_q(e.sel) != e.q || cur_wrap(e.sel) !== e.wrap) begin
        miscompares++;
        $display("FAIL q/wrap sel=%0d vec=%0d: got q=%0d wrap=%b want q=%0d wrap=%b",
                 e.sel, vectors, cur_q(e.sel), cur_wrap(e.sel), e.q, e.wrap);
      end
    end
  end
  task automatic step(input int sel, input bit c, input bit p, input bit l, input bit e,
                      input bit u, input int v, input int eq, input bit ew, input bit et);
    @(negedge clk);
    clear = c; preset = p; load = l; en = e; up = u; lv = 5'(v);
    sb.push_back('{sel: sel, q: eq, wrap: ew, tc: et});
  endtask
  initial begin
    int pre;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) begin
      pre = (32 - i) % 32;
      step(0, 0, 0, 0, 1, 0, 0, pre == 0 ? 31 : pre - 1, pre == 0, pre == 0);
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      pre = i % 10;
      step(1, 0, 0, 0, 1, 1, 0, (i + 1) % 10, pre == 9, pre == 9);
    end
    step(1, 0, 0, 1, 0, 0, 13, 9, 0, 0);
    step(1, 0, 0, 1, 1, 1, 4, 4, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 5, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 6, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 5, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 4, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 9, 1, 1);
    step(1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    step(1, 1, 1, 1, 1, 1, 3, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 3, 9, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 9, 0, 0);
    step(1, 0, 0, 1, 0, 0, 31, 9, 0, 0);
    step(1, 0, 0, 1, 0, 0, 7, 7, 0, 0);
    step(1, 1, 0, 1, 1, 1, 2, 0, 0, 0);
    step(2, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++)
      step(2, 0, 0, 0, 1, 1, 0, (i + 1) % 100, i == 99, i == 99);
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
